// File: rtl/uart_alu_pkg.sv
// Shared types, default widths and the frame-tag decoder for the UART/ALU command path.
package uart_alu_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;
    localparam int unsigned NB_TAG_DEF  = 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EXEC    = 2'd1,
        SEND    = 2'd2,
        WAIT_TX = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TAG_OPERAND = 2'd0,
        TAG_OPCODE  = 2'd1,
        TAG_INVALID = 2'd2
    } tag_kind_e;

    // Tags below the operand count address operand slots, the next tag is
    // the opcode, and anything above that does not name a slot.
    function automatic tag_kind_e decode_tag(input int unsigned tag,
                                             input int unsigned nOperands);
        if (tag < nOperands) begin
            return TAG_OPERAND;
        end else if (tag == nOperands) begin
            return TAG_OPCODE;
        end else begin
            return TAG_INVALID;
        end
    endfunction

endpackage

// File: rtl/uart_alu_timeout_counter.sv
// Idle counter for partially collected commands: counts while enabled and
// fires a single-cycle expiry when it reaches the programmed terminal value.
module uart_alu_timeout_counter #(
    parameter int unsigned NB_CNT = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [NB_CNT-1:0] limit_i,
    output logic              expire_o
);

    logic [NB_CNT-1:0] count_q;
    logic [NB_CNT-1:0] count_d;

    // Clear wins over expiry so a frame landing on the terminal cycle keeps the command alive.
    always_comb begin
        expire_o = enable_i && !clear_i && (count_q == limit_i);
        count_d  = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_alu_cmd_ctrl.sv
// Command controller: gathers tagged UART frames into operand/opcode slots,
// fires the ALU once all slots are written, and sends the result back out.
module uart_alu_cmd_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DEF,
    parameter int unsigned NB_OP          = NB_OP_DEF,
    parameter int unsigned N_OPERANDS     = 2,
    parameter int unsigned NB_TAG         = NB_TAG_DEF,
    parameter int unsigned NB_FRAME       = NB_TAG + NB_DATA,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NB_FRAME-1:0]            i_rx_data,
    input  logic                           i_rx_done,
    input  logic                           i_tx_busy,
    input  logic [NB_DATA-1:0]             i_alu_result,
    output logic [N_OPERANDS*NB_DATA-1:0]  o_operands,
    output logic [NB_OP-1:0]               o_opcode,
    output logic                           o_alu_valid,
    output logic [NB_DATA-1:0]             o_tx_data,
    output logic                           o_tx_start,
    output logic                           o_frame_err,
    output logic                           o_overrun,
    output logic                           o_timeout
);

    localparam int unsigned NB_FLAGS = N_OPERANDS + 1;
    localparam int unsigned NB_CNT   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] TO_LIMIT =
        (TIMEOUT_CYCLES > 0) ? NB_CNT'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TO_ENABLED = (TIMEOUT_CYCLES != 0);

    state_e                          state_q;
    logic [NB_FLAGS-1:0]             flags_q;
    logic [N_OPERANDS*NB_DATA-1:0]   operands_q;
    logic [NB_OP-1:0]                opcode_q;
    logic [NB_DATA-1:0]              txData_q;
    logic                            aluValid_q;
    logic                            txStart_q;
    logic                            frameErr_q;
    logic                            overrun_q;
    logic                            timeout_q;
    logic                            seenBusy_q;

    logic [NB_TAG-1:0]               rxTag;
    logic [NB_DATA-1:0]              rxPayload;
    tag_kind_e                       rxKind;
    logic                            rxValidTag;
    logic                            frameAccept;
    logic [NB_FLAGS-1:0]             setMask;
    logic                            commandDone;
    logic                            toClear;
    logic                            toEnable;
    logic                            toExpire;

    assign rxTag       = i_rx_data[NB_FRAME-1:NB_DATA];
    assign rxPayload   = i_rx_data[NB_DATA-1:0];
    assign rxKind      = decode_tag(32'(rxTag), N_OPERANDS);
    assign rxValidTag  = (rxKind != TAG_INVALID);
    assign frameAccept = i_rx_done && (state_q == COLLECT) && rxValidTag;

    // A valid tag value doubles as its flag index (operands first, opcode last).
    assign setMask     = {{N_OPERANDS{1'b0}}, 1'b1} << rxTag;
    assign commandDone = &(flags_q | setMask);

    // The idle timer only runs while a partial command sits in COLLECT.
    assign toClear  = (state_q != COLLECT) || frameAccept || (flags_q == '0);
    assign toEnable = TO_ENABLED && (state_q == COLLECT) && (flags_q != '0);

    uart_alu_timeout_counter #(
        .NB_CNT (NB_CNT)
    ) u_timeout (
        .clk_i    (i_clk),
        .rst_i    (i_reset),
        .clear_i  (toClear),
        .enable_i (toEnable),
        .limit_i  (TO_LIMIT),
        .expire_o (toExpire)
    );

    // Main controller FSM; every output is a register so pulses are clean single cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= COLLECT;
            flags_q    <= '0;
            operands_q <= '0;
            opcode_q   <= '0;
            txData_q   <= '0;
            aluValid_q <= 1'b0;
            txStart_q  <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            seenBusy_q <= 1'b0;
        end else begin
            aluValid_q <= 1'b0;
            txStart_q  <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;

            case (state_q)
                COLLECT: begin
                    if (i_rx_done && !rxValidTag) begin
                        frameErr_q <= 1'b1;
                    end
                    if (frameAccept) begin
                        flags_q <= flags_q | setMask;
                        if (rxKind == TAG_OPCODE) begin
                            opcode_q <= rxPayload[NB_OP-1:0];
                        end else begin
                            for (int k = 0; k < int'(N_OPERANDS); k++) begin
                                if (rxTag == NB_TAG'(k)) begin
                                    operands_q[k*NB_DATA +: NB_DATA] <= rxPayload;
                                end
                            end
                        end
                        if (commandDone) begin
                            aluValid_q <= 1'b1;
                            state_q    <= EXEC;
                        end
                    end else if (toExpire) begin
                        flags_q   <= '0;
                        timeout_q <= 1'b1;
                    end
                end

                EXEC: begin
                    txData_q <= i_alu_result;
                    flags_q  <= '0;
                    state_q  <= SEND;
                end

                SEND: begin
                    if (!i_tx_busy) begin
                        txStart_q  <= 1'b1;
                        seenBusy_q <= 1'b0;
                        state_q    <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (i_tx_busy) begin
                        seenBusy_q <= 1'b1;
                    end else if (seenBusy_q) begin
                        state_q <= COLLECT;
                    end
                end

                default: begin
                    state_q <= COLLECT;
                end
            endcase

            if ((state_q != COLLECT) && i_rx_done) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign o_operands  = operands_q;
    assign o_opcode    = opcode_q;
    assign o_alu_valid = aluValid_q;
    assign o_tx_data   = txData_q;
    assign o_tx_start  = txStart_q;
    assign o_frame_err = frameErr_q;
    assign o_overrun   = overrun_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// Directed bench for uart_alu_cmd_ctrl: a two-operand instance with a short
// timeout and a three-operand instance, checked against hand-computed values.
module tb_uart_alu_cmd_ctrl;

   logic clk;
   logic rst;

   logic [9:0]  aRxData;
   logic        aRxDone;
   logic        aTxBusy;
   logic [7:0]  aAluResult;
   logic [15:0] aOperands;
   logic [5:0]  aOpcode;
   logic        aAluValid;
   logic [7:0]  aTxData;
   logic        aTxStart;
   logic        aFrameErr;
   logic        aOverrun;
   logic        aTimeout;

   logic [9:0]  bRxData;
   logic        bRxDone;
   logic        bTxBusy;
   logic [7:0]  bAluResult;
   logic [23:0] bOperands;
   logic [5:0]  bOpcode;
   logic        bAluValid;
   logic [7:0]  bTxData;
   logic        bTxStart;
   logic        bFrameErr;
   logic        bOverrun;
   logic        bTimeout;

   int compareCount;
   int mismatchCount;

   uart_alu_cmd_ctrl #(
      .N_OPERANDS     (2),
      .NB_TAG         (2),
      .TIMEOUT_CYCLES (16)
   ) dutA (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_rx_data    (aRxData),
      .i_rx_done    (aRxDone),
      .i_tx_busy    (aTxBusy),
      .i_alu_result (aAluResult),
      .o_operands   (aOperands),
      .o_opcode     (aOpcode),
      .o_alu_valid  (aAluValid),
      .o_tx_data    (aTxData),
      .o_tx_start   (aTxStart),
      .o_frame_err  (aFrameErr),
      .o_overrun    (aOverrun),
      .o_timeout    (aTimeout)
   );

   uart_alu_cmd_ctrl #(
      .N_OPERANDS (3),
      .NB_TAG     (2)
   ) dutB (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_rx_data    (bRxData),
      .i_rx_done    (bRxDone),
      .i_tx_busy    (bTxBusy),
      .i_alu_result (bAluResult),
      .o_operands   (bOperands),
      .o_opcode     (bOpcode),
      .o_alu_valid  (bAluValid),
      .o_tx_data    (bTxData),
      .o_tx_start   (bTxStart),
      .o_frame_err  (bFrameErr),
      .o_overrun    (bOverrun),
      .o_timeout    (bTimeout)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle frame strobe into instance A.
   task automatic applyStimulus(input logic [9:0] frame);
      aRxData = frame;
      aRxDone = 1'b1;
      tick();
      aRxDone = 1'b0;
   endtask

   // One-cycle frame strobe into instance B.
   task automatic applyStimulusB(input logic [9:0] frame);
      bRxData = frame;
      bRxDone = 1'b1;
      tick();
      bRxDone = 1'b0;
   endtask

   // Called in the EXEC cycle of instance A with an idle transmitter.
   task automatic completeSend(input logic [7:0] expTx);
      tick();
      checkOutput("sendNoStartYet", 32'(aTxStart), 32'h0);
      checkOutput("txDataLatched", 32'(aTxData), 32'(expTx));
      tick();
      checkOutput("txStart", 32'(aTxStart), 32'h1);
      tick();
      checkOutput("txStartOneCycle", 32'(aTxStart), 32'h0);
      aTxBusy = 1'b1;
      tick();
      aTxBusy = 1'b0;
      tick();
   endtask

   // Linear directed sequence.
   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      rst        = 1'b1;
      aRxData    = '0;
      aRxDone    = 1'b0;
      aTxBusy    = 1'b0;
      aAluResult = '0;
      bRxData    = '0;
      bRxDone    = 1'b0;
      bTxBusy    = 1'b0;
      bAluResult = '0;

      tick();
      tick();
      checkOutput("rstOperands", 32'(aOperands), 32'h0);
      checkOutput("rstOpcode", 32'(aOpcode), 32'h0);
      checkOutput("rstAluValid", 32'(aAluValid), 32'h0);
      checkOutput("rstTxData", 32'(aTxData), 32'h0);
      checkOutput("rstTxStart", 32'(aTxStart), 32'h0);
      checkOutput("rstPulses", {29'h0, aFrameErr, aOverrun, aTimeout}, 32'h0);
      checkOutput("rstB", {bOperands, 2'b0, bOpcode}, 32'h0);
      checkOutput("rstBPulses", {26'h0, bAluValid, bTxStart, bFrameErr, bOverrun, bTimeout, 1'b0}, 32'h0);
      checkOutput("rstBTxData", 32'(bTxData), 32'h0);
      rst = 1'b0;
      tick();

      $display("[TB] basic command");
      aAluResult = 8'h08;
      applyStimulus(10'h005);
      checkOutput("basicNoValid0", 32'(aAluValid), 32'h0);
      applyStimulus(10'h103);
      checkOutput("basicNoValid1", 32'(aAluValid), 32'h0);
      applyStimulus(10'h220);
      checkOutput("basicAluValid", 32'(aAluValid), 32'h1);
      checkOutput("basicOperands", 32'(aOperands), 32'h0305);
      checkOutput("basicOpcode", 32'(aOpcode), 32'h20);
      completeSend(8'h08);
      checkOutput("basicValidOneCycle", 32'(aAluValid), 32'h0);

      $display("[TB] invalid tag");
      aAluResult = 8'h5A;
      applyStimulus(10'h0AA);
      applyStimulus(10'h3FF);
      checkOutput("badTagFrameErr", 32'(aFrameErr), 32'h1);
      checkOutput("badTagNoOverrun", 32'(aOverrun), 32'h0);
      tick();
      checkOutput("badTagPulseWidth", 32'(aFrameErr), 32'h0);
      applyStimulus(10'h155);
      checkOutput("badTagNoComplete", 32'(aAluValid), 32'h0);
      applyStimulus(10'h211);
      checkOutput("badTagThenValid", 32'(aAluValid), 32'h1);
      checkOutput("badTagOperands", 32'(aOperands), 32'h55AA);
      checkOutput("badTagOpcode", 32'(aOpcode), 32'h11);
      completeSend(8'h5A);

      $display("[TB] timeout");
      aAluResult = 8'h77;
      applyStimulus(10'h005);
      for (int i = 0; i < 15; i++) tick();
      checkOutput("timeoutNotYet", 32'(aTimeout), 32'h0);
      tick();
      checkOutput("timeoutPulse", 32'(aTimeout), 32'h1);
      tick();
      checkOutput("timeoutPulseWidth", 32'(aTimeout), 32'h0);
      applyStimulus(10'h103);
      applyStimulus(10'h220);
      checkOutput("timeoutDiscarded", 32'(aAluValid), 32'h0);
      for (int i = 0; i < 15; i++) tick();
      applyStimulus(10'h005);
      checkOutput("coincideNoTimeout", 32'(aTimeout), 32'h0);
      checkOutput("coincideFrameWins", 32'(aAluValid), 32'h1);
      checkOutput("coincideOperands", 32'(aOperands), 32'h0305);
      completeSend(8'h77);

      $display("[TB] busy hold and overrun");
      aTxBusy    = 1'b1;
      aAluResult = 8'h99;
      applyStimulus(10'h0C3);
      applyStimulus(10'h13C);
      applyStimulus(10'h207);
      checkOutput("busyAluValid", 32'(aAluValid), 32'h1);
      checkOutput("busyOperands", 32'(aOperands), 32'h3CC3);
      checkOutput("busyOpcode", 32'(aOpcode), 32'h07);
      tick();
      tick();
      tick();
      checkOutput("busyHoldsSend", 32'(aTxStart), 32'h0);
      applyStimulus(10'h3FF);
      checkOutput("overrunPulse", 32'(aOverrun), 32'h1);
      checkOutput("overrunNoFrameErr", 32'(aFrameErr), 32'h0);
      checkOutput("overrunNoStart", 32'(aTxStart), 32'h0);
      tick();
      checkOutput("overrunPulseWidth", 32'(aOverrun), 32'h0);
      checkOutput("overrunDropped", {aOperands, 10'h0, aOpcode}, {16'h3CC3, 10'h0, 6'h07});
      aTxBusy = 1'b0;
      tick();
      checkOutput("releaseTxStart", 32'(aTxStart), 32'h1);
      checkOutput("releaseTxData", 32'(aTxData), 32'h99);

      $display("[TB] async reset in WAIT_TX");
      aTxBusy = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncRstTxData", 32'(aTxData), 32'h0);
      checkOutput("asyncRstOperands", 32'(aOperands), 32'h0);
      checkOutput("asyncRstOpcode", 32'(aOpcode), 32'h0);
      checkOutput("asyncRstStrobes", {27'h0, aAluValid, aTxStart, aFrameErr, aOverrun, aTimeout}, 32'h0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      aTxBusy = 1'b0;
      tick();
      tick();
      checkOutput("afterRstNoStart", 32'(aTxStart), 32'h0);
      aAluResult = 8'h03;
      applyStimulus(10'h001);
      applyStimulus(10'h102);
      applyStimulus(10'h203);
      checkOutput("afterRstAluValid", 32'(aAluValid), 32'h1);
      checkOutput("afterRstOperands", 32'(aOperands), 32'h0201);
      checkOutput("afterRstOpcode", 32'(aOpcode), 32'h03);
      completeSend(8'h03);

      $display("[TB] three operands");
      applyStimulusB(10'h011);
      applyStimulusB(10'h122);
      applyStimulusB(10'h233);
      checkOutput("threeOpNoValid", 32'(bAluValid), 32'h0);
      checkOutput("threeOpNoFrameErr", 32'(bFrameErr), 32'h0);
      applyStimulusB(10'h30A);
      checkOutput("threeOpAluValid", 32'(bAluValid), 32'h1);
      checkOutput("threeOpOperands", 32'(bOperands), 32'h332211);
      checkOutput("threeOpOpcode", 32'(bOpcode), 32'h0A);
      tick();
      checkOutput("threeOpValidWidth", 32'(bAluValid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
